// File: rtl/mat_pkg.sv
// Shared constants, FSM state type and element addressing helpers for
// the 5x5 signed 8-bit matrix multiplier front end.
package mat_pkg;

    localparam int MAT_N     = 5;
    localparam int MAT_W     = 8;
    localparam int MAT_ELEMS = MAT_N * MAT_N;
    localparam int MAT_BITS  = MAT_ELEMS * MAT_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mat_state_t;

    // Bit offset of element k inside a flattened 200-bit matrix bus
    function automatic int elem_off(input logic [4:0] idx);
        return int'(idx) * MAT_W;
    endfunction

    // True when an element index addresses one of the 25 real elements
    function automatic logic idx_ok(input logic [4:0] idx);
        return int'(idx) < MAT_ELEMS;
    endfunction

endpackage

// File: rtl/mat_mul_ctrl_if.sv
// Bus bundle between the HPS-side host / multiplier core (master) and
// the mat_mul_ctrl front end (slave).
interface mat_mul_ctrl_if;

    logic                        wr_en;
    logic                        wr_sel;
    logic [4:0]                  wr_addr;
    logic [7:0]                  wr_data;
    logic                        clr;
    logic                        start;
    logic [4:0]                  rd_addr;
    logic [7:0]                  rd_data;
    logic                        busy;
    logic                        result_valid;
    logic                        overflow;
    logic                        err;
    logic [mat_pkg::MAT_BITS-1:0] mat_a;
    logic [mat_pkg::MAT_BITS-1:0] mat_b;
    logic                        mul_en;
    logic                        mul_done;
    logic                        mul_ovf;
    logic [mat_pkg::MAT_BITS-1:0] mul_out;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, clr, start, rd_addr,
               mul_done, mul_ovf, mul_out,
        input  rd_data, busy, result_valid, overflow, err,
               mat_a, mat_b, mul_en
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, clr, start, rd_addr,
               mul_done, mul_ovf, mul_out,
        output rd_data, busy, result_valid, overflow, err,
               mat_a, mat_b, mul_en
    );

endinterface

// File: rtl/mat_bank.sv
// 25 x 8-bit operand register bank with byte write port, synchronous
// clear and a flattened 200-bit view for the multiplier.
module mat_bank
    import mat_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                we,
    input  logic [4:0]          waddr,
    input  logic [MAT_W-1:0]    wdata,
    output logic [MAT_BITS-1:0] flat
);

    logic [MAT_BITS-1:0] bank_q;

    // Clear wipes the bank; otherwise store one element, dropping out-of-range indices
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            bank_q <= '0;
        end else if (we && idx_ok(waddr)) begin
            bank_q[elem_off(waddr) +: MAT_W] <= wdata;
        end
    end

    assign flat = bank_q;

endmodule

// File: rtl/mat_mul_ctrl.sv
// Front-end controller for the 5x5 signed 8-bit matrix multiplier.
// Loads operand banks A/B, runs the en/done handshake, captures the
// product and overflow, and serves product elements by index.
// Optional watchdog on the RUN state is compiled in with MAT_TIMEOUT_EN.
module mat_mul_ctrl
    import mat_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    mat_mul_ctrl_if.slave bus
);

    mat_state_t          state_q, state_d;
    logic                run_first_q;
    logic                go, accept, timeout_hit;
    logic                wr_ok, clr_ok;
    logic [MAT_BITS-1:0] product_q;
    logic                result_valid_q, overflow_q;
    logic [MAT_W-1:0]    rd_data_q;
    logic [MAT_BITS-1:0] bank_a_flat, bank_b_flat;

    // Operands are frozen while the multiplier runs, so writes and clear only act outside RUN
    assign wr_ok  = bus.wr_en && (state_q != ST_RUN);
    assign clr_ok = bus.clr && (state_q != ST_RUN);
    assign go     = bus.start && !bus.clr && (state_q != ST_RUN);
    // A done seen on the first RUN cycle may be left over from the previous run
    assign accept = (state_q == ST_RUN) && !run_first_q && bus.mul_done;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (go) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (accept)           state_d = ST_DONE;
                else if (timeout_hit) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Marks the first RUN cycle so a stale done is not taken
    always_ff @(posedge clk) begin
        if (rst) begin
            run_first_q <= 1'b0;
        end else begin
            run_first_q <= go;
        end
    end

`ifdef MAT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] run_cnt_q;
    logic          err_q;

    // Counts RUN cycles, restarting from zero on every entry into RUN
    always_ff @(posedge clk) begin
        if (rst || state_q != ST_RUN) begin
            run_cnt_q <= '0;
        end else begin
            run_cnt_q <= run_cnt_q + CW'(1);
        end
    end

    assign timeout_hit = (state_q == ST_RUN) && !accept && (run_cnt_q == CW'(TIMEOUT - 1));

    // Sticky watchdog flag, cleared by clear or by a new start
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (clr_ok || go) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.err     = 1'b0;
`endif

    // Product capture and result status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            product_q      <= '0;
            result_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else if (clr_ok || go) begin
            result_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else if (accept) begin
            product_q      <= bus.mul_out;
            overflow_q     <= bus.mul_ovf;
            result_valid_q <= 1'b1;
        end
    end

    // Registered product read port, zero for bad index or no valid result
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (result_valid_q && idx_ok(bus.rd_addr)) begin
            rd_data_q <= product_q[elem_off(bus.rd_addr) +: MAT_W];
        end else begin
            rd_data_q <= '0;
        end
    end

    mat_bank u_bank_a (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_ok),
        .we    (wr_ok && !bus.wr_sel),
        .waddr (bus.wr_addr),
        .wdata (bus.wr_data),
        .flat  (bank_a_flat)
    );

    mat_bank u_bank_b (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_ok),
        .we    (wr_ok && bus.wr_sel),
        .waddr (bus.wr_addr),
        .wdata (bus.wr_data),
        .flat  (bank_b_flat)
    );

    assign bus.mat_a        = bank_a_flat;
    assign bus.mat_b        = bank_b_flat;
    assign bus.busy         = (state_q == ST_RUN);
    assign bus.mul_en       = (state_q == ST_RUN);
    assign bus.result_valid = result_valid_q;
    assign bus.overflow     = overflow_q;
    assign bus.rd_data      = rd_data_q;

endmodule

// File: tb/tb_mat_mul_ctrl.sv
// Directed self-checking bench for mat_mul_ctrl. The bench plays both
// the host and the multiplier core. Built with MAT_TIMEOUT_EN it checks
// the watchdog, otherwise that RUN waits indefinitely.
module tb_mat_mul_ctrl;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0] ma [25];
    logic [7:0] mb [25];

    mat_mul_ctrl_if bus ();

    mat_mul_ctrl #(.TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case anything stalls
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: sim time exceeded, want summary first");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_elem(input logic sel, input logic [4:0] addr, input logic [7:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    // Reference signed 5x5 product, each element truncated to 8 bits
    function automatic logic [199:0] model_product();
        logic [199:0] p;
        int acc;
        p = '0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                acc = 0;
                for (int k = 0; k < 5; k++) begin
                    acc += int'($signed(ma[i*5+k])) * int'($signed(mb[k*5+j]));
                end
                p[(i*5+j)*8 +: 8] = 8'(acc);
            end
        end
        return p;
    endfunction

    function automatic logic [199:0] pack_b();
        logic [199:0] f;
        for (int k = 0; k < 25; k++) f[k*8 +: 8] = mb[k];
        return f;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.mul_en !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_mul_en: got %b want 0", bus.mul_en); end
        n_cmp++; if (bus.result_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_valid: got %b want 0", bus.result_valid); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_ovf: got %b want 0", bus.overflow); end
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_err: got %b want 0", bus.err); end
        n_cmp++; if (bus.rd_data !== 8'h00) begin n_bad++; $display("[TB] FAIL reset_rd_data: got %h want 00", bus.rd_data); end
        n_cmp++; if (bus.mat_a !== '0) begin n_bad++; $display("[TB] FAIL reset_mat_a: got %h want 0", bus.mat_a); end
        n_cmp++; if (bus.mat_b !== '0) begin n_bad++; $display("[TB] FAIL reset_mat_b: got %h want 0", bus.mat_b); end
    endtask

    task automatic test_identity();
        for (int k = 0; k < 25; k++) begin
            ma[k] = (k % 6 == 0) ? 8'd1 : 8'd0;
            mb[k] = 8'(k);
            write_elem(1'b0, 5'(k), ma[k]);
            write_elem(1'b1, 5'(k), mb[k]);
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("[TB] FAIL id_busy: got %b want 1", bus.busy); end
        n_cmp++; if (bus.mul_en !== 1'b1) begin n_bad++; $display("[TB] FAIL id_mul_en: got %b want 1", bus.mul_en); end
        n_cmp++; if (bus.mat_a[7:0] !== 8'h01) begin n_bad++; $display("[TB] FAIL id_a0: got %h want 01", bus.mat_a[7:0]); end
        n_cmp++; if (bus.mat_b[199:192] !== 8'h18) begin n_bad++; $display("[TB] FAIL id_b24: got %h want 18", bus.mat_b[199:192]); end
        tick();
        tick();
        tick();
        bus.mul_out  = model_product();
        bus.mul_done = 1'b1;
        tick();
        bus.mul_done = 1'b0;
        n_cmp++; if (bus.result_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL id_valid: got %b want 1", bus.result_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL id_busy_done: got %b want 0", bus.busy); end
        n_cmp++; if (bus.mul_en !== 1'b0) begin n_bad++; $display("[TB] FAIL id_mul_en_done: got %b want 0", bus.mul_en); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL id_ovf: got %b want 0", bus.overflow); end
        for (int k = 0; k < 25; k++) begin
            bus.rd_addr = 5'(k);
            tick();
            n_cmp++; if (bus.rd_data !== 8'(k)) begin n_bad++; $display("[TB] FAIL id_read[%0d]: got %h want %h", k, bus.rd_data, 8'(k)); end
        end
        bus.rd_addr = 5'd25;
        tick();
        n_cmp++; if (bus.rd_data !== 8'h00) begin n_bad++; $display("[TB] FAIL id_read25: got %h want 00", bus.rd_data); end
        bus.rd_addr = 5'd31;
        tick();
        n_cmp++; if (bus.rd_data !== 8'h00) begin n_bad++; $display("[TB] FAIL id_read31: got %h want 00", bus.rd_data); end
    endtask

    task automatic test_overflow();
        bus.mul_done = 1'b1;
        bus.mul_ovf  = 1'b1;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("[TB] FAIL ovf_busy1: got %b want 1", bus.busy); end
        n_cmp++; if (bus.result_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL ovf_valid_cleared: got %b want 0", bus.result_valid); end
        tick();
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("[TB] FAIL ovf_stale_done: busy got %b want 1", bus.busy); end
        n_cmp++; if (bus.result_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL ovf_stale_valid: got %b want 0", bus.result_valid); end
        tick();
        bus.mul_done = 1'b0;
        bus.mul_ovf  = 1'b0;
        n_cmp++; if (bus.result_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL ovf_valid: got %b want 1", bus.result_valid); end
        n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("[TB] FAIL ovf_flag: got %b want 1", bus.overflow); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL ovf_busy_done: got %b want 0", bus.busy); end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("[TB] FAIL ovf_clear_on_start: got %b want 0", bus.overflow); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("[TB] FAIL ovf_rerun_busy: got %b want 1", bus.busy); end
        tick();
        bus.mul_done = 1'b1;
        tick();
        bus.mul_done = 1'b0;
        n_cmp++; if (bus.result_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL ovf_rerun_valid: got %b want 1", bus.result_valid); end
    endtask

    task automatic test_write_freeze();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        write_elem(1'b0, 5'd0, 8'h7F);
        n_cmp++; if (bus.mat_a[7:0] !== 8'h01) begin n_bad++; $display("[TB] FAIL frz_run_write: got %h want 01", bus.mat_a[7:0]); end
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        n_cmp++; if (bus.mat_b[15:8] !== 8'h01) begin n_bad++; $display("[TB] FAIL frz_run_clr: got %h want 01", bus.mat_b[15:8]); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("[TB] FAIL frz_busy: got %b want 1", bus.busy); end
        bus.mul_done = 1'b1;
        tick();
        bus.mul_done = 1'b0;
        write_elem(1'b0, 5'd0, 8'h7F);
        n_cmp++; if (bus.mat_a[7:0] !== 8'h7F) begin n_bad++; $display("[TB] FAIL frz_done_write: got %h want 7f", bus.mat_a[7:0]); end
        n_cmp++; if (bus.result_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL frz_done_valid: got %b want 1", bus.result_valid); end
        write_elem(1'b1, 5'd25, 8'hAA);
        n_cmp++; if (bus.mat_b !== pack_b()) begin n_bad++; $display("[TB] FAIL frz_addr25: got %h want %h", bus.mat_b, pack_b()); end
        bus.rd_addr = 5'd7;
        tick();
        n_cmp++; if (bus.rd_data !== 8'h07) begin n_bad++; $display("[TB] FAIL frz_read7: got %h want 07", bus.rd_data); end
    endtask

    task automatic test_reset_mid_run();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.mul_done = 1'b1;
        bus.mul_out  = {25{8'hA5}};
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL rmr_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.mul_en !== 1'b0) begin n_bad++; $display("[TB] FAIL rmr_mul_en: got %b want 0", bus.mul_en); end
        n_cmp++; if (bus.result_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rmr_valid: got %b want 0", bus.result_valid); end
        n_cmp++; if (bus.rd_data !== 8'h00) begin n_bad++; $display("[TB] FAIL rmr_rd_data: got %h want 00", bus.rd_data); end
        n_cmp++; if (bus.mat_a !== '0) begin n_bad++; $display("[TB] FAIL rmr_mat_a: got %h want 0", bus.mat_a); end
        n_cmp++; if (bus.mat_b !== '0) begin n_bad++; $display("[TB] FAIL rmr_mat_b: got %h want 0", bus.mat_b); end
        tick();
        bus.mul_done = 1'b0;
        n_cmp++; if (bus.result_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rmr_done_ignored: got %b want 0", bus.result_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL rmr_busy_after: got %b want 0", bus.busy); end
        bus.rd_addr = 5'd25;
        tick();
        n_cmp++; if (bus.rd_data !== 8'h00) begin n_bad++; $display("[TB] FAIL rmr_read25: got %h want 00", bus.rd_data); end
    endtask

    task automatic test_write_with_start();
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b0;
        bus.wr_addr = 5'd3;
        bus.wr_data = 8'h05;
        bus.start   = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("[TB] FAIL ws_busy: got %b want 1", bus.busy); end
        n_cmp++; if (bus.mat_a[31:24] !== 8'h05) begin n_bad++; $display("[TB] FAIL ws_a3: got %h want 05", bus.mat_a[31:24]); end
        n_cmp++; if (bus.mat_a[23:0] !== 24'h0) begin n_bad++; $display("[TB] FAIL ws_a_low: got %h want 000000", bus.mat_a[23:0]); end
        tick();
        bus.mul_done = 1'b1;
        tick();
        bus.mul_done = 1'b0;
        n_cmp++; if (bus.result_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL ws_valid: got %b want 1", bus.result_valid); end
    endtask

    task automatic test_clr_start();
        bus.clr   = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.clr   = 1'b0;
        bus.start = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL cs_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.mul_en !== 1'b0) begin n_bad++; $display("[TB] FAIL cs_mul_en: got %b want 0", bus.mul_en); end
        n_cmp++; if (bus.mat_a !== '0) begin n_bad++; $display("[TB] FAIL cs_mat_a: got %h want 0", bus.mat_a); end
        n_cmp++; if (bus.result_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL cs_valid: got %b want 0", bus.result_valid); end
        tick();
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL cs_busy_later: got %b want 0", bus.busy); end
    endtask

    task automatic test_timeout();
        bus.mul_done = 1'b0;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
`ifdef MAT_TIMEOUT_EN
        repeat (15) tick();
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("[TB] FAIL to_busy_before: got %b want 1", bus.busy); end
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("[TB] FAIL to_err_before: got %b want 0", bus.err); end
        tick();
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("[TB] FAIL to_busy_after: got %b want 0", bus.busy); end
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("[TB] FAIL to_err_after: got %b want 1", bus.err); end
        n_cmp++; if (bus.mul_en !== 1'b0) begin n_bad++; $display("[TB] FAIL to_mul_en: got %b want 0", bus.mul_en); end
        n_cmp++; if (bus.result_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL to_valid: got %b want 0", bus.result_valid); end
`else
        repeat (100) tick();
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("[TB] FAIL hang_busy: got %b want 1", bus.busy); end
        n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("[TB] FAIL hang_err: got %b want 0", bus.err); end
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Test sequence
    initial begin
        rst          = 1'b1;
        bus.wr_en    = 1'b0;
        bus.wr_sel   = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.clr      = 1'b0;
        bus.start    = 1'b0;
        bus.rd_addr  = '0;
        bus.mul_done = 1'b0;
        bus.mul_ovf  = 1'b0;
        bus.mul_out  = '0;

        test_reset();
        test_identity();
        test_overflow();
        test_write_freeze();
        test_reset_mid_run();
        test_write_with_start();
        test_clr_start();
        test_timeout();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mat_mul_ctrl.md
# mat_mul_ctrl

Front-end controller for the 5x5 signed 8-bit matrix multiplier. It collects matrix A and B elements one byte at a time from the HPS-side bus into two register banks and drives the flattened 200-bit operand buses into the multiplier. It runs the multiplier's `en`/`done` handshake, captures the 200-bit product and the overflow flag, and serves product elements back to the bus by index.

## Interface
- `TIMEOUT`, default 64: maximum RUN cycles before the watchdog fires. Used only with `MAT_TIMEOUT_EN`.
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  element write strobe.
- `wr_sel`  in  1  target bank: 0 = A, 1 = B.
- `wr_addr`  in  5  element index, 5*row+col, valid range 0..24.
- `wr_data`  in  8  element value, two's complement.
- `clr`  in  1  zeroes both banks and clears `result_valid`, `overflow` and `err`.
- `start`  in  1  launches a multiply. One-cycle pulse or level.
- `rd_addr`  in  5  product element index.
- `rd_data`  out  8  product element, registered.
- `busy`  out  1  high while in RUN.
- `result_valid`  out  1  product register holds a completed result.
- `overflow`  out  1  captured multiplier overflow.
- `err`  out  1  watchdog fired. Sticky.
- `mat_a`, `mat_b`  out  200  operand buses. Element k occupies bits [8k+7:8k].
- `mul_en`  out  1  multiplier enable.
- `mul_done`  in  1  multiplier completion.
- `mul_ovf`  in  1  multiplier overflow.
- `mul_out`  in  200  multiplier product, same element layout as `mat_a`.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE + `start` (with `clr` low) -> RUN. Clears `result_valid`, `overflow` and `err`.
- RUN + accepted `mul_done` -> DONE.
  - Latches `mul_out` into the 200-bit product register and `mul_ovf` into `overflow`.
  - Sets `result_valid`.
- RUN + watchdog -> IDLE with `err`=1. Only with `MAT_TIMEOUT_EN`.
- `mul_en` = 1 exactly while in RUN.
- Writes:
  - Accepted in IDLE and DONE. Ignored in RUN, so operands stay frozen.
  - `wr_addr` > 24 is ignored.
  - Writes in DONE do not disturb the product register or `result_valid`.
- Same-cycle events:
  - `wr_en` + `start` in IDLE: the write lands first. The multiplier sees the new value from the first RUN cycle.
  - `clr` + `start`: `clr` wins and `start` is ignored.
  - `clr` during RUN: ignored.
  - `start` during RUN: ignored.
- Reads: `rd_data` <= product[8*rd_addr +: 8] one cycle after `rd_addr`. Reads 0 if `rd_addr` > 24 or `result_valid`=0.
- Arithmetic: none. The block only stores and moves data, and widths are preserved.

## Timing
- Reset values: state IDLE, banks 0, product 0, `rd_data` 0, `busy` 0, `result_valid` 0, `overflow` 0, `err` 0, `mul_en` 0. `mat_a`/`mat_b` therefore read 0.
- `start` sampled at edge t: RUN and `mul_en`=1 from t+1.
- `mul_done` is ignored on the first RUN cycle, because it may be stale from the previous run. It is accepted from the second RUN cycle onward.
- `mul_done` accepted at edge d: DONE, `result_valid`=1 and `mul_en`=0 from d+1. The minimum start-to-`result_valid` latency is 3 edges.
- `mul_en` is low for at least one cycle between runs.
- `rst` asserted mid-RUN: returns to reset values at the next edge, and the product register is not updated.

## Configuration
- `MAT_TIMEOUT_EN` defined:
  - An RUN-cycle counter, width $clog2(TIMEOUT+1), increments each RUN cycle.
  - If `mul_done` has not been accepted after `TIMEOUT` RUN cycles, the FSM goes to IDLE and sets `err`=1.
  - `result_valid` stays 0.
- `MAT_TIMEOUT_EN` undefined:
  - No counter. RUN waits indefinitely.
  - `err` is tied to 0.

## Structure
- Package `mat_pkg` holds:
  - `MAT_N`=5, `MAT_W`=8, `MAT_ELEMS`=25, `MAT_BITS`=200.
  - The state enum type.
  - An element-slice helper function, index -> bit offset 8k.
- Sub-module `mat_bank`: a 25x8 register file with write port, clear, and flattened 200-bit output. It is instantiated twice, once for A and once for B.

## Test plan
- A = identity (elements 0, 6, 12, 18, 24 = 1, rest 0), B[k]=k, `start`, model returns A*B after 4 cycles -> `result_valid`=1 and `rd_data`(k) = k for all k, `overflow`=0.
- Model asserts `mul_ovf`=1 with `mul_done` -> `overflow`=1. A later `start` clears it to 0 on the next edge.
- During RUN, write A[0]=0x7F -> `mat_a[7:0]` is unchanged. The same write after DONE -> 0x7F, and `result_valid` stays 1.
- `wr_en` (A[3]=0x05) with `start` in the same cycle -> the first RUN cycle shows `mat_a[31:24]`=0x05. `clr`+`start` -> stays IDLE and banks read 0.
- `MAT_TIMEOUT_EN`, `TIMEOUT`=16, `mul_done` held low -> `err`=1 and IDLE after 16 RUN cycles, `mul_en` low. Without the macro, `busy` stays 1 after 100 cycles.
- `rst` pulse on the 2nd RUN cycle -> all outputs return to reset values. `mul_done` asserted in the following cycle is ignored. `rd_addr`=25 -> `rd_data`=0.
